// File: rtl/alu_ctrl_mdu_pkg.sv
// Shared encodings for the ALU control decoder and the iterative multiply/divide unit.
// Function codes, ALU op codes, HI/LO select values and MDU state codes live here.
package alu_ctrl_mdu_pkg;

  localparam logic [1:0] AOP_ADD   = 2'b00;
  localparam logic [1:0] AOP_EQ    = 2'b01;
  localparam logic [1:0] AOP_RTYPE = 2'b10;
  localparam logic [1:0] AOP_RSVD  = 2'b11;

  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_SRL   = 6'h02;
  localparam logic [5:0] F_JR    = 6'h08;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_SLT   = 6'h2A;

  localparam logic [3:0] ALU_NONE = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLL  = 4'd6;
  localparam logic [3:0] ALU_SRL  = 4'd7;
  localparam logic [3:0] ALU_EQ   = 4'd8;

  localparam logic [1:0] HILO_NONE = 2'b00;
  localparam logic [1:0] HILO_HI   = 2'b01;
  localparam logic [1:0] HILO_LO   = 2'b10;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIX  = 2'd3;

  typedef struct packed {
    logic [3:0] alu_ctrl;
    logic       jr;
    logic [1:0] hilo_sel;
    logic       md;
  } dec_t;

  function automatic dec_t decode(input logic [1:0] op, input logic [5:0] f);
    dec_t d;
    d = '0;
    case (op)
      AOP_ADD: d.alu_ctrl = ALU_ADD;
      AOP_EQ:  d.alu_ctrl = ALU_EQ;
      AOP_RTYPE: begin
        case (f)
          F_ADD, F_ADDU: d.alu_ctrl = ALU_ADD;
          F_SUB, F_SUBU: d.alu_ctrl = ALU_SUB;
          F_AND:         d.alu_ctrl = ALU_AND;
          F_OR:          d.alu_ctrl = ALU_OR;
          F_SLT:         d.alu_ctrl = ALU_SLT;
          F_SLL:         d.alu_ctrl = ALU_SLL;
          F_SRL:         d.alu_ctrl = ALU_SRL;
          F_JR:          d.jr       = 1'b1;
          F_MFHI:        d.hilo_sel = HILO_HI;
          F_MFLO:        d.hilo_sel = HILO_LO;
          F_MULT, F_MULTU, F_DIV, F_DIVU: d.md = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_ctrl_mdu_core.sv
// Iterative multiply/divide unit: shift-add multiply, restoring divide, one bit per cycle,
// signs stripped on issue and reapplied in a single fix-up cycle before HI/LO are written.
module mdu_core
  import alu_ctrl_mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_op,
  input  logic             div_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic               neg_q, neg_r, div_zero, is_div;

  logic               sign_a, sign_b;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH+1:0]   div_diff;
  logic               div_ok;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem, fix_hi, fix_lo;
  logic               last;

  always_comb begin
    sign_a = signed_op & a[WIDTH-1];
    sign_b = signed_op & b[WIDTH-1];
    mag_a  = sign_a ? (~a + WIDTH'(1)) : a;
    mag_b  = sign_b ? (~b + WIDTH'(1)) : b;

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_next = {mul_sum, acc[WIDTH-1:1]};

    // Divide: acc = {remainder, dividend bits then quotient bits}, shifted left each step.
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, opnd};
    div_ok    = ~div_diff[WIDTH+1];
    div_next  = {(div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]), acc[WIDTH-2:0], div_ok};

    prod = neg_q ? (~acc + (2*WIDTH)'(1)) : acc;
    quo  = acc[WIDTH-1:0];
    rem  = acc[2*WIDTH-1:WIDTH];
    if (is_div) begin
      fix_lo = div_zero ? '1 : (neg_q ? (~quo + WIDTH'(1)) : quo);
      fix_hi = neg_r ? (~rem + WIDTH'(1)) : rem;
    end else begin
      fix_lo = prod[WIDTH-1:0];
      fix_hi = prod[2*WIDTH-1:WIDTH];
    end

    last = (cnt == CNT_W'(WIDTH - 1));
    busy = (state != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      is_div   <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= div_op ? S_DIV : S_MUL;
            cnt      <= '0;
            opnd     <= div_op ? mag_b : mag_a;
            acc      <= {{WIDTH{1'b0}}, (div_op ? mag_a : mag_b)};
            neg_q    <= sign_a ^ sign_b;
            neg_r    <= sign_a;
            div_zero <= div_op & (b == '0);
            is_div   <= div_op;
          end
        end
        S_MUL: begin
          acc <= mul_next;
          cnt <= cnt + CNT_W'(1);
          if (last) state <= S_FIX;
        end
        S_DIV: begin
          acc <= div_next;
          cnt <= cnt + CNT_W'(1);
          if (last) state <= S_FIX;
        end
        S_FIX: begin
          hi    <= fix_hi;
          lo    <= fix_lo;
          cnt   <= '0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/alu_ctrl_mdu.sv
// ALU control decoder with attached multiply/divide unit, HI/LO read-out mux and
// pipeline stall generation for HI/LO hazards and back-to-back mul/div issue.
module alu_ctrl_mdu
  import alu_ctrl_mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic             valid,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic [3:0]       alu_ctrl,
  output logic             jr,
  output logic [1:0]       hilo_sel,
  output logic [WIDTH-1:0] hilo_data,
  output logic             stall,
  output logic             busy
);

  dec_t             dec;
  logic             md_op;
  logic [WIDTH-1:0] hi, lo;
  logic             core_busy;

  always_comb begin
    dec      = decode(alu_op, funct);
    alu_ctrl = dec.alu_ctrl;
    jr       = dec.jr;
    hilo_sel = dec.hilo_sel;
    md_op    = valid & dec.md;
  end

  // funct[0] clear selects the signed variant, funct[1] set selects divide.
  mdu_core #(.WIDTH(WIDTH)) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (md_op),
    .signed_op (~funct[0]),
    .div_op    (funct[1]),
    .a         (rs_data),
    .b         (rt_data),
    .hi        (hi),
    .lo        (lo),
    .busy      (core_busy)
  );

  always_comb begin
    busy  = core_busy;
    stall = core_busy & ((hilo_sel != HILO_NONE) | md_op);
    case (hilo_sel)
      HILO_HI: hilo_data = hi;
      HILO_LO: hilo_data = lo;
      default: hilo_data = '0;
    endcase
  end

endmodule
